action_scheduler: RTL and testbench

ACTION_SCHEDULER -- requirements
Module: action_scheduler

---
 rtl/click_pkg.sv | 22 ++
 rtl/action_fifo.sv | 64 ++++++
 rtl/action_scheduler.sv | 169 ++++++++++++++++
 tb/tb_action_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/click_pkg.sv
// Shared op codes and click-state type for the action scheduler.
package click_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned NUM_SRC = 5;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_NONE    = 3'b000;
    localparam op_t OP_BTNC    = 3'b001;
    localparam op_t OP_DBLBTNC = 3'b010;
    localparam op_t OP_U       = 3'b100;
    localparam op_t OP_R       = 3'b101;
    localparam op_t OP_D       = 3'b110;
    localparam op_t OP_L       = 3'b111;

    typedef enum logic {
        IDLE   = 1'b0,
        WINDOW = 1'b1
    } click_state_t;

endpackage

// File: rtl/action_fifo.sv
// Power-of-two action queue; push and pop may coincide at any occupancy, including full.
module action_fifo
    import click_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  op_t  data,
    output op_t  head,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    op_t              mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    // A pop frees a slot in the same cycle, so a full queue may still accept a push alongside it.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        full    = (count == CNT_W'(FIFO_DEPTH));
        empty   = (count == '0);
        head    = empty ? OP_NONE : mem[rd_ptr];
    end

    // Storage array; no reset needed since head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/action_scheduler.sv
// Button-to-action scheduler: edge detect, C click resolution, pending arbitration, action queue.
// Optional feature: define CLICK_DBLCLK_EN to resolve single/double C clicks over a DBL_WINDOW window;
// otherwise every C press is an immediate single-click action.
module action_scheduler
    import click_pkg::*;
#(
    parameter int unsigned DBL_WINDOW = 25000000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       btnC,
    input  logic       btnU,
    input  logic       btnR,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       ack,
    output logic [2:0] action,
    output logic       valid,
    output logic       overflow
);

    // Elaboration-time guard on parameter ranges.
    if (DBL_WINDOW < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("action_scheduler: DBL_WINDOW >= 2 and power-of-two FIFO_DEPTH >= 2 required");
    end

    // Source bit order is also arbitration order: [4]=C, [3]=U, [2]=R, [1]=D, [0]=L.
    logic [NUM_SRC-1:0] lvl;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] press;
    logic [NUM_SRC-1:0] evt;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] sel;
    op_t                c_evt;
    op_t                c_op;
    op_t                push_op;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    // Level registers load the live level during clear so held buttons never look like presses.
    always_ff @(posedge clk) begin
        if (clear) begin
            lvl  <= {btnC, btnU, btnR, btnD, btnL};
            prev <= {btnC, btnU, btnR, btnD, btnL};
        end else begin
            lvl  <= {btnC, btnU, btnR, btnD, btnL};
            prev <= lvl;
        end
    end

    assign press = lvl & ~prev;

`ifdef CLICK_DBLCLK_EN
    localparam int unsigned WIN_W = $clog2(DBL_WINDOW);

    click_state_t     state;
    click_state_t     state_nxt;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_cnt_nxt;

    // Click state and window counter registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            win_cnt <= '0;
        end else begin
            state   <= state_nxt;
            win_cnt <= win_cnt_nxt;
        end
    end

    // Second press inside the window wins over a coincident expiry.
    always_comb begin
        state_nxt   = state;
        win_cnt_nxt = win_cnt;
        c_evt       = OP_NONE;
        case (state)
            IDLE: begin
                if (press[4]) begin
                    state_nxt   = WINDOW;
                    win_cnt_nxt = '0;
                end
            end
            WINDOW: begin
                win_cnt_nxt = win_cnt + 1'b1;
                if (press[4]) begin
                    c_evt       = OP_DBLBTNC;
                    state_nxt   = IDLE;
                    win_cnt_nxt = '0;
                end else if (win_cnt == WIN_W'(DBL_WINDOW - 1)) begin
                    c_evt       = OP_BTNC;
                    state_nxt   = IDLE;
                    win_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                win_cnt_nxt = '0;
            end
        endcase
    end
`else
    // Without double-click resolution every C press is a single click.
    assign c_evt = press[4] ? OP_BTNC : OP_NONE;
`endif

    assign evt = {c_evt != OP_NONE, press[3:0]};

    // Pick the highest-priority pending source and its op code.
    always_comb begin
        sel     = '0;
        push_op = OP_NONE;
        if (pend[4]) begin
            sel     = 5'b10000;
            push_op = c_op;
        end else if (pend[3]) begin
            sel     = 5'b01000;
            push_op = OP_U;
        end else if (pend[2]) begin
            sel     = 5'b00100;
            push_op = OP_R;
        end else if (pend[1]) begin
            sel     = 5'b00010;
            push_op = OP_D;
        end else if (pend[0]) begin
            sel     = 5'b00001;
            push_op = OP_L;
        end
    end

    assign push = |pend;
    assign pop  = ack && !empty;

    // Pending bits: the selected source retires (queued or dropped); new events set their bit.
    always_ff @(posedge clk) begin
        if (clear) begin
            pend     <= '0;
            c_op     <= OP_NONE;
            overflow <= 1'b0;
        end else begin
            pend <= (pend & ~sel) | evt;
            if (c_evt != OP_NONE) begin
                c_op <= c_evt;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    action_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .clear(clear),
        .push (push),
        .pop  (pop),
        .data (push_op),
        .head (action),
        .full (full),
        .empty(empty)
    );

    assign valid = !empty;

endmodule

// File: tb/tb_action_scheduler.sv
// Scoreboard bench for action_scheduler (DBL_WINDOW=8, FIFO_DEPTH=4); honours CLICK_DBLCLK_EN.
module tb_action_scheduler;
    import click_pkg::*;

    localparam int unsigned DBL_WINDOW = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    logic       clk   = 1'b0;
    logic       clear = 1'b1;
    logic       btnC  = 1'b0;
    logic       btnU  = 1'b0;
    logic       btnR  = 1'b0;
    logic       btnD  = 1'b0;
    logic       btnL  = 1'b0;
    logic       ack   = 1'b0;
    logic [2:0] action;
    logic       valid;
    logic       overflow;

    always #5 clk = ~clk;

    action_scheduler #(
        .DBL_WINDOW(DBL_WINDOW),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .clear   (clear),
        .btnC    (btnC),
        .btnU    (btnU),
        .btnR    (btnR),
        .btnD    (btnD),
        .btnL    (btnL),
        .ack     (ack),
        .action  (action),
        .valid   (valid),
        .overflow(overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Presses come from the level history; the C window is tracked by its start cycle;
    // the queue is an ordered list of expected ops plus an occupancy number.
    logic [4:0] m_lvl, m_prev, m_pend;
    op_t        m_cop;
    bit         m_open;
    int         m_start;
    int         m_cnt;
    bit         m_ovf;
    int         cyc;
    op_t        exp_q[$];

    function automatic op_t dir_op(int i);
        case (i)
            3:       return OP_U;
            2:       return OP_R;
            1:       return OP_D;
            default: return OP_L;
        endcase
    endfunction

    initial begin
        m_lvl = '0; m_prev = '0; m_pend = '0; m_cop = OP_NONE;
        m_open = 0; m_start = 0; m_cnt = 0; m_ovf = 0; cyc = 0;
    end

    always @(posedge clk) begin
        logic [4:0] raw;
        logic [4:0] pr;
        op_t        cev;
        bit         do_pop;
        int         s;
        int         age;
        cyc++;
        raw = {btnC, btnU, btnR, btnD, btnL};
        if (clear) begin
            m_lvl = raw; m_prev = raw; m_pend = '0; m_cop = OP_NONE;
            m_open = 0; m_cnt = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            pr  = m_lvl & ~m_prev;
            cev = OP_NONE;
`ifdef CLICK_DBLCLK_EN
            if (m_open) begin
                age = cyc - m_start - 1;
                if (pr[4]) begin
                    cev = OP_DBLBTNC; m_open = 0;
                end else if (age == int'(DBL_WINDOW) - 1) begin
                    cev = OP_BTNC; m_open = 0;
                end
            end else if (pr[4]) begin
                m_open = 1; m_start = cyc;
            end
`else
            age = 0;
            if (pr[4]) cev = OP_BTNC;
`endif
            do_pop = ack && (m_cnt > 0);
            s = -1;
            for (int i = 4; i >= 0; i--) if (m_pend[i] && s < 0) s = i;
            if (s >= 0) begin
                if (m_cnt < int'(FIFO_DEPTH) || do_pop) begin
                    exp_q.push_back(s == 4 ? m_cop : dir_op(s));
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                end
                m_pend[s] = 1'b0;
            end
            if (do_pop) m_cnt--;
            if (cev != OP_NONE) begin
                m_pend[4] = 1'b1;
                m_cop     = cev;
            end
            m_pend[3:0] = m_pend[3:0] | pr[3:0];
            m_prev = m_lvl;
            m_lvl  = raw;
        end
    end

    // ---------------- monitors ----------------
    // Consumed entries are popped from the scoreboard and compared.
    always @(posedge clk) begin
        if (!clear && valid === 1'b1 && ack) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got action %0d expected no entry at %0t", action, $time);
            end else begin
                check("pop_action", action, exp_q.pop_front());
            end
        end
    end

    // Status flags compared every cycle away from the active edge.
    always @(negedge clk) begin
        check("valid", valid, (m_cnt != 0));
        check("overflow", overflow, m_ovf);
        if (valid !== 1'b1) check("empty_action", action, OP_NONE);
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btns(logic [4:0] v);
        {btnC, btnU, btnR, btnD, btnL} = v;
    endtask

    // Pulse buttons for one cycle and return cycles until valid rises (0 = never within budget).
    task automatic pulse_latency(logic [4:0] v, int budget, output int lat);
        lat = 0;
        set_btns(v);
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (n == 1) set_btns('0);
            if (valid === 1'b1 && lat == 0) lat = n;
        end
    endtask

    initial begin
        int lat;
        logic [4:0] lv;
        // Held button across reset release must not count as a press.
        set_btns(5'b01000);
        tick(3);
        clear = 1'b0;
        tick(5);
        check("held_at_release", valid, 1'b0);
        set_btns('0);
        tick(2);

        // Single direction press latency and ack.
        pulse_latency(5'b01000, 6, lat);
        check("u_latency", lat, 3);
        check("u_action", action, OP_U);
        ack = 1'b1; tick(); ack = 1'b0;
        check("u_ack_valid", valid, 1'b0);
        check("u_ack_action", action, OP_NONE);
        tick(2);

        // Single C click.
        pulse_latency(5'b10000, 20, lat);
`ifdef CLICK_DBLCLK_EN
        check("c_single_latency", lat, 3 + DBL_WINDOW);
`else
        check("c_single_latency", lat, 3);
`endif
        check("c_single_action", action, OP_BTNC);
        ack = 1'b1; tick(); ack = 1'b0;
        tick(3);

`ifdef CLICK_DBLCLK_EN
        // Double click: second press five cycles after the first.
        set_btns(5'b10000); tick(); set_btns('0); tick(4);
        set_btns(5'b10000); tick(); set_btns('0); tick(14);
        check("c_double_action", action, OP_DBLBTNC);
        ack = 1'b1; tick(); ack = 1'b0;
        tick(2);
        check("c_double_only_one", valid, 1'b0);
`endif

        // Four directions together fill the queue in priority order, then extra presses drop.
        pulse_latency(5'b01111, 8, lat);
        check("multi_latency", lat, 3);
        check("multi_head", action, OP_U);
        set_btns(5'b01100); tick(); set_btns('0); tick(5);
        check("full_overflow", overflow, 1'b1);
        ack = 1'b1; tick(4); ack = 1'b0;
        check("drained_valid", valid, 1'b0);
        check("drained_overflow", overflow, 1'b1);

        // Clear mid-window with entries queued discards everything.
        set_btns(5'b01100); tick(); set_btns('0); tick(5);
        set_btns(5'b10000); tick(); set_btns('0); tick(3);
        clear = 1'b1; tick(); clear = 1'b0;
        check("clear_valid", valid, 1'b0);
        check("clear_overflow", overflow, 1'b0);
        tick(DBL_WINDOW + 6);
        check("clear_no_late_event", valid, 1'b0);

        // Randomized phases: vary toggle density and ack rate, rare clears.
        for (int ph = 0; ph < 6; ph++) begin
            int ack_pct;
            int tog_pct;
            ack_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 90);
            tog_pct = (ph < 3) ? 15 : 40;
            for (int c = 0; c < 500; c++) begin
                lv = {btnC, btnU, btnR, btnD, btnL};
                for (int b = 0; b < 5; b++)
                    if ($urandom_range(99) < tog_pct) lv[b] = ~lv[b];
                set_btns(lv);
                ack   = ($urandom_range(99) < ack_pct);
                clear = ($urandom_range(399) == 0);
                tick();
            end
        end

        // Drain remaining work.
        clear = 1'b0;
        set_btns('0);
        ack = 1'b1;
        tick(DBL_WINDOW + 20);
        check("final_empty", valid, 1'b0);
        ack = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
